// File: rtl/img_pkg.sv
// Shared types and BMP header constants for the frame capture block.
package img_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    localparam int         BMP_HDR_BYTES = 54;
    localparam int         BMP_DIB_SIZE  = 40;
    localparam int         BMP_PLANES    = 1;
    localparam int         BMP_BPP       = 24;
    localparam int         BMP_RES_PPM   = 2835;
    localparam logic [7:0] BMP_SIG_B     = 8'h42;
    localparam logic [7:0] BMP_SIG_M     = 8'h4D;

    // Whole header as one little-endian vector: byte 0 sits in bits [7:0].
    function automatic logic [BMP_HDR_BYTES*8-1:0] bmp_header(input int w, input int h);
        logic [31:0] img;
        img = 32'(w * h * 3);
        return {32'd0, 32'd0, 32'(BMP_RES_PPM), 32'(BMP_RES_PPM), img, 32'd0,
                16'(BMP_BPP), 16'(BMP_PLANES), 32'(h), 32'(w), 32'(BMP_DIB_SIZE),
                32'(BMP_HDR_BYTES), 32'd0, img + 32'(BMP_HDR_BYTES), BMP_SIG_M, BMP_SIG_B};
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational BMP header byte lookup, indexed 0..53; other indices read 0.
module bmp_header_rom
    import img_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic [5:0] idx,
    output logic [7:0] data
);

    localparam logic [BMP_HDR_BYTES*8-1:0] HDR = bmp_header(WIDTH, HEIGHT);

    // Byte select out of the constant header vector.
    always_comb begin
        data = 8'h00;
        if (idx < 6'(BMP_HDR_BYTES))
            data = HDR[{idx, 3'b000} +: 8];
    end

endmodule

// File: rtl/image_frame_capture.sv
// Captures one two-pixel-per-cycle RGB frame into a bottom-up BGR byte
// buffer, then drains it as a valid/ready byte stream.
// Optional: define IMG_BMP_HEADER_EN to prepend the 54-byte BMP header.
module image_frame_capture
    import img_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       VSYNC,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       overrun,
    output logic       ctrl_done
);

    localparam int NPAIRS    = WIDTH * HEIGHT / 2;
    localparam int ROW_BYTES = WIDTH * 3;
    localparam int PIX_BYTES = ROW_BYTES * HEIGHT;
`ifdef IMG_BMP_HEADER_EN
    localparam int HDR       = BMP_HDR_BYTES;
`else
    localparam int HDR       = 0;
`endif
    localparam int TOTAL     = PIX_BYTES + HDR;
    localparam int PW        = $clog2(NPAIRS + 1);
    localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CW        = $clog2(WIDTH);
    localparam int AW        = $clog2(PIX_BYTES);
    localparam int DW        = $clog2(TOTAL);

    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 2);

    state_t          state_q, state_d;
    logic [PW-1:0]   pair_cnt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [DW-1:0]   rd_idx;
    logic            vsync_q;
    logic            abort, clr, wr_en, last_pair;
    logic [AW-1:0]   wr_base;
    logic [7:0]      rd_byte;
    logic [7:0]      mem [PIX_BYTES];

    assign abort     = (state_q == CAPTURE) && VSYNC && !vsync_q && (pair_cnt != '0);
    assign last_pair = (pair_cnt == PW'(NPAIRS - 1));
    assign wr_base   = AW'(ROW_LAST - row) * AW'(ROW_BYTES) + AW'(col) * AW'(3);
    assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
    assign ctrl_done = (state_q == DONE);

`ifdef IMG_BMP_HEADER_EN
    logic [7:0] hdr_byte;

    bmp_header_rom #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_hdr (
        .idx  (6'(rd_idx)),
        .data (hdr_byte)
    );

    // Header bytes first, pixel bytes shifted up by the header length.
    always_comb begin
        rd_byte = hdr_byte;
        if (rd_idx >= DW'(HDR))
            rd_byte = mem[AW'(rd_idx - DW'(HDR))];
    end
`else
    // Drain index maps straight onto the pixel buffer.
    always_comb begin
        rd_byte = mem[AW'(rd_idx)];
    end
`endif

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus counter clear / buffer write strobes.
    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (VSYNC) begin
                    clr     = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    clr = 1'b1;
                end else if (HSYNC) begin
                    wr_en = 1'b1;
                    if (last_pair) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid && out_ready && out_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame-start edge detect for the mid-capture restart.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) vsync_q <= 1'b0;
        else        vsync_q <= VSYNC;
    end

    // Pair / column / row position of the next incoming pair.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pair_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (clr) begin
            pair_cnt <= '0;
            row      <= '0;
            col      <= '0;
        end else if (wr_en) begin
            pair_cnt <= pair_cnt + PW'(1);
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(2);
            end
        end
    end

    // Six-byte pair write, B,G,R per pixel, into the flipped row.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wr_base + AW'(0)] <= DATA_B0;
            mem[wr_base + AW'(1)] <= DATA_G0;
            mem[wr_base + AW'(2)] <= DATA_R0;
            mem[wr_base + AW'(3)] <= DATA_B1;
            mem[wr_base + AW'(4)] <= DATA_G1;
            mem[wr_base + AW'(5)] <= DATA_R1;
        end
    end

    // Registered drain stage: reload only when empty or the byte was taken.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 8'h00;
            rd_idx    <= '0;
        end else if (clr) begin
            rd_idx    <= '0;
        end else if (state_q == DRAIN) begin
            if (out_valid && out_ready && out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (!out_valid || out_ready) begin
                out_data  <= rd_byte;
                out_valid <= 1'b1;
                out_last  <= (rd_idx == DW'(TOTAL - 1));
                rd_idx    <= rd_idx + DW'(1);
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Sticky flag for pairs arriving while the buffer is being drained.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            overrun <= 1'b0;
        else if (state_q == IDLE && VSYNC)
            overrun <= 1'b0;
        else if ((state_q == DRAIN || state_q == DONE) && HSYNC)
            overrun <= 1'b1;
    end

endmodule

// File: tb/tb_image_frame_capture.sv
// Randomized bench for image_frame_capture against a frame-level byte model.
// Honours IMG_BMP_HEADER_EN the same way the design does.
module tb_image_frame_capture;

    localparam int W  = 4;
    localparam int H  = 2;
`ifdef IMG_BMP_HEADER_EN
    localparam int HDR = 54;
`else
    localparam int HDR = 0;
`endif
    localparam int TOTAL = W * H * 3 + HDR;

    logic       HCLK = 1'b0, HRESET = 1'b0, VSYNC = 1'b0, HSYNC = 1'b0;
    logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic       out_valid, out_ready = 1'b0, out_last, busy, overrun, ctrl_done;
    logic [7:0] out_data;

    image_frame_capture #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .overrun(overrun), .ctrl_done(ctrl_done)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    bit [7:0] pr [H][W];
    bit [7:0] pg [H][W];
    bit [7:0] pb [H][W];
    bit [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                pr[r][c] = 8'(r * W + c);
                pg[r][c] = 8'(8'h10 + r * W + c);
                pb[r][c] = 8'(8'h20 + r * W + c);
            end
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                pr[r][c] = 8'($urandom);
                pg[r][c] = 8'($urandom);
                pb[r][c] = 8'($urandom);
            end
    endtask

    task automatic push_le(input int v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(8'((v >> (8 * i)) & 255));
    endtask

    // Expected drain: optional header, then input rows last-to-first, B,G,R.
    task automatic build_exp();
        exp_q.delete();
`ifdef IMG_BMP_HEADER_EN
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(54 + W * H * 3, 4);
        push_le(0, 4);
        push_le(54, 4);
        push_le(40, 4);
        push_le(W, 4);
        push_le(H, 4);
        push_le(1, 2);
        push_le(24, 2);
        push_le(0, 4);
        push_le(W * H * 3, 4);
        push_le(2835, 4);
        push_le(2835, 4);
        push_le(0, 4);
        push_le(0, 4);
`endif
        for (int ob = 0; ob < H; ob++)
            for (int c = 0; c < W; c++) begin
                exp_q.push_back(pb[H-1-ob][c]);
                exp_q.push_back(pg[H-1-ob][c]);
                exp_q.push_back(pr[H-1-ob][c]);
            end
    endtask

    task automatic drive_pair(input int r, input int c, input bit junk);
        HSYNC   = 1'b1;
        DATA_R0 = junk ? ~pr[r][c]   : pr[r][c];
        DATA_G0 = junk ? ~pg[r][c]   : pg[r][c];
        DATA_B0 = junk ? ~pb[r][c]   : pb[r][c];
        DATA_R1 = junk ? ~pr[r][c+1] : pr[r][c+1];
        DATA_G1 = junk ? ~pg[r][c+1] : pg[r][c+1];
        DATA_B1 = junk ? ~pb[r][c+1] : pb[r][c+1];
        @(negedge HCLK);
        HSYNC = 1'b0;
    endtask

    // Frame start, optional junk pairs + restart, then the real frame.
    task automatic capture(input int abort_after, input int max_gap);
        VSYNC = 1'b1;
        @(negedge HCLK);
        VSYNC = 1'b0;
        chk("start_busy", busy, 1);
        chk("overrun_clr", overrun, 0);
        if (abort_after > 0) begin
            for (int p = 0; p < abort_after; p++) drive_pair(0, 2 * p, 1'b1);
            @(negedge HCLK);
            VSYNC = 1'b1;
            @(negedge HCLK);
            VSYNC = 1'b0;
            chk("abort_busy", busy, 1);
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c += 2) begin
                int gap;
                gap = $urandom_range(max_gap, 0);
                for (int g = 0; g < gap; g++) @(negedge HCLK);
                drive_pair(r, c, 1'b0);
            end
        chk("drain_busy", busy, 1);
        chk("drain_nvalid", out_valid, 0);
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready.
    task automatic drain(input int mode, input int rst_at, input bit inject);
        int n, cyc, ph;
        bit pend, r;
        bit [7:0] held;
        n = 0; cyc = 0; ph = 0; pend = 0; held = 0;
        out_ready = 1'b1;
        @(negedge HCLK);
        chk("first_valid", out_valid, 1);
        while (n < TOTAL && cyc < 4 * TOTAL + 50) begin
            if (pend) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
            if (rst_at >= 0 && n == rst_at) begin
                HRESET = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_data", out_data, 0);
                @(negedge HCLK);
                HRESET    = 1'b0;
                out_ready = 1'b0;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (ph % 4 == 0) || (ph % 4 == 3);
                default: r = 1'(($urandom >> 3) & 1);
            endcase
            ph++;
            if (inject && n == 5) begin
                HSYNC   = 1'b1;
                DATA_R0 = 8'($urandom);
                DATA_B1 = 8'($urandom);
            end else begin
                HSYNC = 1'b0;
            end
            out_ready = r;
            if (out_valid && r) begin
                chk("byte", out_data, exp_q[n]);
                chk("last", out_last, (n == TOTAL - 1));
                n++;
                pend = 0;
            end else begin
                pend = out_valid;
                held = out_data;
            end
            @(negedge HCLK);
            cyc++;
        end
        HSYNC     = 1'b0;
        out_ready = 1'b0;
        if (n < TOTAL) begin
            chk("drain_timeout", n, TOTAL);
        end else begin
            chk("done_pulse", ctrl_done, 1);
            chk("valid_drop", out_valid, 0);
            chk("last_drop", out_last, 0);
            @(negedge HCLK);
            chk("done_clear", ctrl_done, 0);
            chk("idle_busy", busy, 0);
            chk("overrun", overrun, inject);
        end
    endtask

    initial begin
        #1 HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        chk("rst_valid0", out_valid, 0);
        chk("rst_last0", out_last, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_overrun0", overrun, 0);
        chk("rst_done0", ctrl_done, 0);
        chk("rst_data0", out_data, 0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Pairs with no frame start are ignored.
        fill_pattern();
        drive_pair(0, 0, 1'b0);
        drive_pair(0, 2, 1'b0);
        chk("idle_hsync_busy", busy, 0);

        // Basic frame, then the same frame under 1,0,0,1 backpressure.
        build_exp();
        capture(0, 0);
        drain(0, -1, 1'b0);
        capture(0, 0);
        drain(1, -1, 1'b0);

        // Restart after two accepted pairs.
        fill_random();
        build_exp();
        capture(2, 2);
        drain(2, -1, 1'b0);

        // Pairs arriving during drain are dropped and flagged.
        fill_random();
        build_exp();
        capture(0, 1);
        drain(0, -1, 1'b1);

        // Reset in the middle of a drain, then a clean frame.
        fill_random();
        build_exp();
        capture(0, 0);
        drain(0, 10, 1'b0);
        fill_random();
        build_exp();
        capture(0, 2);
        drain(2, -1, 1'b0);

        for (int f = 0; f < 3; f++) begin
            fill_random();
            build_exp();
            capture(0, 3);
            drain(2, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
